// File: rtl/pc_seq_pkg.sv
// Shared constants and helpers for the program-counter sequencer.
package pc_seq_pkg;

    localparam int AW_DEF         = 16;
    localparam int NIRQ_DEF       = 4;
    localparam int DEPTH_DEF      = 4;
    localparam int VEC_BASE_DEF   = 2;
    localparam int VEC_STRIDE_DEF = 2;

    // Widest interrupt vector the priority encoder handles.
    localparam int MAX_NIRQ  = 32;
    localparam int IRQ_IDX_W = 5;

    // Index of the lowest set bit; zero when no bit is set.
    function automatic logic [IRQ_IDX_W-1:0] lowest_index(input logic [MAX_NIRQ-1:0] req);
        logic [IRQ_IDX_W-1:0] idx;
        idx = {IRQ_IDX_W{1'b0}};
        for (int i = MAX_NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IRQ_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Only the level is reset; stale entries are never read.
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                din,
    output logic [AW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   lvl,
    output logic                         full,
    output logic                         empty
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [LW-1:0] LVL_ONE = {{(LW-1){1'b0}}, 1'b1};

    logic [AW-1:0] mem_r [DEPTH];
    logic [LW-1:0] lvl_r;
    logic [IW-1:0] wr_idx_s;
    logic [IW-1:0] rd_idx_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (lvl_r == LW'(DEPTH));
    assign empty     = (lvl_r == {LW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign wr_idx_s  = IW'(lvl_r);
    assign rd_idx_s  = IW'(lvl_r - LVL_ONE);
    assign dout      = mem_r[rd_idx_s];
    assign lvl       = lvl_r;

    // Store the pushed address in the slot just above the current top.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    // Track the number of live entries; reset discards everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_r <= {LW{1'b0}};
        end else if (push_ok_s) begin
            lvl_r <= lvl_r + LVL_ONE;
        end else if (pop_ok_s) begin
            lvl_r <= lvl_r - LVL_ONE;
        end else begin
            lvl_r <= lvl_r;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jumps, vectored nested interrupts and reti.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int NIRQ       = NIRQ_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int VEC_BASE   = VEC_BASE_DEF,
    parameter int VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AW-1:0]                alu_in,
    input  logic                         abs_jmp,
    input  logic                         rel_jmp,
    input  logic                         stall,
    input  logic [NIRQ-1:0]              irq,
    input  logic                         irq_en,
    input  logic                         reti,
    output logic [AW-1:0]                pc,
    output logic [AW-1:0]                next_pc,
    output logic [NIRQ-1:0]              irq_ack,
    output logic                         in_isr,
    output logic                         stk_full,
    output logic [$clog2(DEPTH+1)-1:0]   stk_lvl,
    output logic                         stk_err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]   ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [NIRQ-1:0] IRQ_ONE  = {{(NIRQ-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]   LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};

    logic [AW-1:0]        pc_r;
    logic [AW-1:0]        next_pc_r;
    logic [NIRQ-1:0]      irq_ack_r;
    logic                 in_isr_r;
    logic                 stk_err_r;

    logic [AW-1:0]        pc_nxt_s;
    logic [NIRQ-1:0]      ack_nxt_s;
    logic [LW-1:0]        lvl_nxt_s;
    logic                 err_set_s;
    logic                 take_s;
    logic                 push_s;
    logic                 pop_s;
    logic [AW-1:0]        ret_addr_s;
    logic [AW-1:0]        pop_addr_s;
    logic [AW-1:0]        vec_s;
    logic [MAX_NIRQ-1:0]  irq_wide_s;
    logic [IRQ_IDX_W-1:0] irq_idx_s;
    logic [NIRQ-1:0]      irq_onehot_s;
    logic [LW-1:0]        stk_lvl_s;
    logic                 stk_full_s;
    logic                 stk_empty_s;

    // Interrupt selection: lowest asserted channel and its vector address.
    assign irq_wide_s   = MAX_NIRQ'(irq);
    assign irq_idx_s    = lowest_index(irq_wide_s);
    assign irq_onehot_s = irq & (~irq + IRQ_ONE);
    assign vec_s        = AW'(VEC_BASE) + AW'(irq_idx_s) * AW'(VEC_STRIDE);

    // A jump in the interrupted cycle is abandoned, so the ISR returns to pc itself.
    assign ret_addr_s = (rel_jmp | abs_jmp) ? pc_r : pc_r + ADDR_ONE;
    assign take_s     = irq_en & (|irq) & ~stk_full_s;

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (ret_addr_s),
        .dout  (pop_addr_s),
        .lvl   (stk_lvl_s),
        .full  (stk_full_s),
        .empty (stk_empty_s)
    );

    // Resolve the single action for this cycle in priority order.
    always_comb begin
        pc_nxt_s  = pc_r + ADDR_ONE;
        ack_nxt_s = {NIRQ{1'b0}};
        err_set_s = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        if (stall) begin
            pc_nxt_s = pc_r;
        end else if (reti) begin
            if (!stk_empty_s) begin
                pop_s    = 1'b1;
                pc_nxt_s = pop_addr_s;
            end else begin
                err_set_s = 1'b1;
                pc_nxt_s  = pc_r + ADDR_ONE;
            end
        end else if (take_s) begin
            push_s    = 1'b1;
            pc_nxt_s  = vec_s;
            ack_nxt_s = irq_onehot_s;
        end else if (rel_jmp) begin
            pc_nxt_s = pc_r + alu_in + ADDR_ONE;
        end else if (abs_jmp) begin
            pc_nxt_s = alu_in;
        end else begin
            pc_nxt_s = pc_r + ADDR_ONE;
        end
    end

    // Stack level after this cycle, used to keep in_isr registered and exact.
    always_comb begin
        lvl_nxt_s = stk_lvl_s;
        if (push_s) begin
            lvl_nxt_s = stk_lvl_s + LVL_ONE;
        end else if (pop_s) begin
            lvl_nxt_s = stk_lvl_s - LVL_ONE;
        end else begin
            lvl_nxt_s = stk_lvl_s;
        end
    end

    // Register every visible output except the combinational stack-full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= {AW{1'b0}};
            next_pc_r <= ADDR_ONE;
            irq_ack_r <= {NIRQ{1'b0}};
            in_isr_r  <= 1'b0;
            stk_err_r <= 1'b0;
        end else begin
            pc_r      <= pc_nxt_s;
            next_pc_r <= pc_nxt_s + ADDR_ONE;
            irq_ack_r <= ack_nxt_s;
            in_isr_r  <= (lvl_nxt_s != {LW{1'b0}});
            stk_err_r <= stk_err_r | err_set_s;
        end
    end

    assign pc       = pc_r;
    assign next_pc  = next_pc_r;
    assign irq_ack  = irq_ack_r;
    assign in_isr   = in_isr_r;
    assign stk_full = stk_full_s;
    assign stk_lvl  = stk_lvl_s;
    assign stk_err  = stk_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int AW    = 16;
    localparam int NIRQ  = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   alu_in;
    logic            abs_jmp, rel_jmp, stall, irq_en, reti;
    logic [NIRQ-1:0] irq;
    logic [AW-1:0]   pc, next_pc;
    logic [NIRQ-1:0] irq_ack;
    logic            in_isr, stk_full, stk_err;
    logic [2:0]      stk_lvl;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_err;
    logic [3:0]  m_ack;

    pc_sequencer #(
        .AW(AW), .NIRQ(NIRQ), .DEPTH(DEPTH), .VEC_BASE(2), .VEC_STRIDE(2)
    ) dut (
        .clk(clk), .rst(rst), .alu_in(alu_in), .abs_jmp(abs_jmp), .rel_jmp(rel_jmp),
        .stall(stall), .irq(irq), .irq_en(irq_en), .reti(reti), .pc(pc), .next_pc(next_pc),
        .irq_ack(irq_ack), .in_isr(in_isr), .stk_full(stk_full), .stk_lvl(stk_lvl),
        .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 16'h0000; m_stack.delete(); m_err = 1'b0; m_ack = 4'b0000;
    endtask

    task automatic model_step();
        int ch;
        m_ack = 4'b0000;
        if (stall) begin
            m_pc = m_pc;
        end else if (reti) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_err = 1'b1; m_pc = m_pc + 16'd1; end
        end else if (irq_en && irq != 4'b0000 && m_stack.size() < DEPTH) begin
            ch = 0;
            while (!irq[ch]) ch++;
            m_stack.push_back((rel_jmp || abs_jmp) ? m_pc : m_pc + 16'd1);
            m_pc  = 16'(2 + 2 * ch);
            m_ack = 4'(1 << ch);
        end else if (rel_jmp) begin
            m_pc = m_pc + alu_in + 16'd1;
        end else if (abs_jmp) begin
            m_pc = alu_in;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [3:0] q, input logic en,
                         input logic rj, input logic aj, input logic [15:0] a);
        stall = s; reti = r; irq = q; irq_en = en; rel_jmp = rj; abs_jmp = aj; alu_in = a;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; model_reset();
        drive(0, 0, 4'b0, 0, 0, 0, 16'h0);
        cycle(); cycle();
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
        total++; if (next_pc !== 16'h0001) begin bad++; $display("FAIL reset_next_pc: got %h want 0001", next_pc); end
        total++; if (stk_lvl !== 3'd0 || in_isr !== 1'b0 || stk_full !== 1'b0) begin bad++; $display("FAIL reset_stack: lvl=%0d isr=%b full=%b want 0/0/0", stk_lvl, in_isr, stk_full); end
        total++; if (irq_ack !== 4'b0 || stk_err !== 1'b0) begin bad++; $display("FAIL reset_flags: ack=%b err=%b want 0000/0", irq_ack, stk_err); end
        rst = 1'b0;
        repeat (5) cycle();
        total++; if (pc !== 16'h0005 || next_pc !== 16'h0006) begin bad++; $display("FAIL idle5: pc=%h next=%h want 0005/0006", pc, next_pc); end
    endtask

    task automatic test_wrap();
        drive(0, 0, 4'b0, 0, 0, 1, 16'hFFFF); cycle();
        total++; if (pc !== 16'hFFFF || next_pc !== 16'h0000) begin bad++; $display("FAIL wrap_top: pc=%h next=%h want ffff/0000", pc, next_pc); end
        drive(0, 0, 4'b0, 0, 0, 0, 16'h0); cycle();
        total++; if (pc !== 16'h0000 || next_pc !== 16'h0001) begin bad++; $display("FAIL wrap_inc: pc=%h next=%h want 0000/0001", pc, next_pc); end
    endtask

    task automatic test_jumps();
        drive(0, 0, 4'b0, 0, 0, 1, 16'h0010); cycle();
        drive(0, 0, 4'b0, 0, 1, 0, 16'hFFFE); cycle();
        total++; if (pc !== 16'h000F || next_pc !== 16'h0010) begin bad++; $display("FAIL rel_neg: pc=%h next=%h want 000f/0010", pc, next_pc); end
        drive(0, 0, 4'b0, 0, 1, 1, 16'h0003); cycle();
        total++; if (pc !== 16'h0013) begin bad++; $display("FAIL rel_over_abs: pc=%h want 0013", pc); end
        drive(0, 0, 4'b0, 0, 0, 1, 16'h1234); cycle();
        total++; if (pc !== 16'h1234 || next_pc !== 16'h1235) begin bad++; $display("FAIL abs: pc=%h next=%h want 1234/1235", pc, next_pc); end
    endtask

    task automatic test_irq_take();
        drive(0, 0, 4'b0, 0, 0, 1, 16'h0020); cycle();
        drive(0, 0, 4'b0110, 1, 0, 0, 16'h0); cycle();
        total++; if (irq_ack !== 4'b0010) begin bad++; $display("FAIL take_ack: got %b want 0010", irq_ack); end
        total++; if (pc !== 16'h0004 || stk_lvl !== 3'd1 || in_isr !== 1'b1) begin bad++; $display("FAIL take_state: pc=%h lvl=%0d isr=%b want 0004/1/1", pc, stk_lvl, in_isr); end
        drive(0, 1, 4'b0, 1, 0, 0, 16'h0); cycle();
        total++; if (pc !== 16'h0021 || stk_lvl !== 3'd0 || in_isr !== 1'b0 || irq_ack !== 4'b0) begin bad++; $display("FAIL reti: pc=%h lvl=%0d isr=%b ack=%b want 0021/0/0/0000", pc, stk_lvl, in_isr, irq_ack); end
    endtask

    task automatic test_reti_priority();
        drive(0, 0, 4'b0, 0, 0, 1, 16'h0040); cycle();
        drive(0, 0, 4'b0100, 1, 0, 0, 16'h0); cycle();
        total++; if (pc !== 16'h0006 || irq_ack !== 4'b0100) begin bad++; $display("FAIL vec2: pc=%h ack=%b want 0006/0100", pc, irq_ack); end
        drive(0, 1, 4'b0100, 1, 0, 0, 16'h0); cycle();
        total++; if (pc !== 16'h0041 || stk_lvl !== 3'd0 || irq_ack !== 4'b0) begin bad++; $display("FAIL reti_wins: pc=%h lvl=%0d ack=%b want 0041/0/0000", pc, stk_lvl, irq_ack); end
        drive(0, 0, 4'b0100, 1, 0, 0, 16'h0); cycle();
        total++; if (irq_ack !== 4'b0100 || pc !== 16'h0006) begin bad++; $display("FAIL retake: ack=%b pc=%h want 0100/0006", irq_ack, pc); end
        drive(0, 1, 4'b0, 0, 0, 0, 16'h0); cycle();
        drive(0, 0, 4'b0, 0, 0, 1, 16'h0050); cycle();
        drive(0, 0, 4'b0001, 1, 0, 1, 16'h0999); cycle();
        total++; if (pc !== 16'h0002 || irq_ack !== 4'b0001) begin bad++; $display("FAIL take_over_jmp: pc=%h ack=%b want 0002/0001", pc, irq_ack); end
        drive(0, 1, 4'b0, 0, 0, 0, 16'h0); cycle();
        total++; if (pc !== 16'h0050) begin bad++; $display("FAIL ret_addr_jmp: pc=%h want 0050", pc); end
    endtask

    task automatic test_nesting();
        drive(0, 0, 4'b0001, 1, 0, 0, 16'h0);
        repeat (4) cycle();
        total++; if (stk_lvl !== 3'd4 || stk_full !== 1'b1 || irq_ack !== 4'b0001) begin bad++; $display("FAIL nest4: lvl=%0d full=%b ack=%b want 4/1/0001", stk_lvl, stk_full, irq_ack); end
        cycle();
        total++; if (irq_ack !== 4'b0 || pc !== 16'h0003 || stk_lvl !== 3'd4) begin bad++; $display("FAIL held_off: ack=%b pc=%h lvl=%0d want 0000/0003/4", irq_ack, pc, stk_lvl); end
        drive(0, 1, 4'b0001, 1, 0, 0, 16'h0); cycle();
        total++; if (stk_lvl !== 3'd3 || stk_full !== 1'b0 || irq_ack !== 4'b0 || pc !== 16'h0003) begin bad++; $display("FAIL full_reti: lvl=%0d full=%b ack=%b pc=%h want 3/0/0000/0003", stk_lvl, stk_full, irq_ack, pc); end
        drive(0, 0, 4'b0001, 1, 0, 0, 16'h0); cycle();
        total++; if (irq_ack !== 4'b0001 || stk_lvl !== 3'd4) begin bad++; $display("FAIL held_taken: ack=%b lvl=%0d want 0001/4", irq_ack, stk_lvl); end
        drive(0, 1, 4'b0, 0, 0, 0, 16'h0);
        repeat (4) cycle();
        total++; if (stk_lvl !== 3'd0 || in_isr !== 1'b0 || stk_err !== 1'b0) begin bad++; $display("FAIL unwind: lvl=%0d isr=%b err=%b want 0/0/0", stk_lvl, in_isr, stk_err); end
    endtask

    task automatic test_err_stall();
        drive(0, 0, 4'b0, 0, 0, 1, 16'h0030); cycle();
        drive(0, 1, 4'b0, 0, 0, 0, 16'h0); cycle();
        total++; if (stk_err !== 1'b1 || pc !== 16'h0031 || stk_lvl !== 3'd0) begin bad++; $display("FAIL reti_empty: err=%b pc=%h lvl=%0d want 1/0031/0", stk_err, pc, stk_lvl); end
        drive(1, 0, 4'b0001, 1, 0, 0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++; if (pc !== 16'h0031 || next_pc !== 16'h0032 || irq_ack !== 4'b0 || stk_lvl !== 3'd0) begin bad++; $display("FAIL stall%0d: pc=%h next=%h ack=%b lvl=%0d want 0031/0032/0000/0", k, pc, next_pc, irq_ack, stk_lvl); end
        end
        drive(0, 0, 4'b0001, 1, 0, 0, 16'h0); cycle();
        total++; if (irq_ack !== 4'b0001 || pc !== 16'h0002 || stk_lvl !== 3'd1) begin bad++; $display("FAIL unstall_take: ack=%b pc=%h lvl=%0d want 0001/0002/1", irq_ack, pc, stk_lvl); end
        drive(0, 1, 4'b0, 0, 0, 0, 16'h0); cycle();
        total++; if (pc !== 16'h0032 || stk_err !== 1'b1) begin bad++; $display("FAIL err_sticky: pc=%h err=%b want 0032/1", pc, stk_err); end
    endtask

    task automatic test_rst_mid_isr();
        drive(0, 0, 4'b0001, 1, 0, 0, 16'h0);
        cycle(); cycle();
        total++; if (stk_lvl !== 3'd2) begin bad++; $display("FAIL pre_rst_lvl: got %0d want 2", stk_lvl); end
        rst = 1'b1; model_reset();
        #1;
        total++; if (pc !== 16'h0000 || next_pc !== 16'h0001) begin bad++; $display("FAIL async_rst_pc: pc=%h next=%h want 0000/0001", pc, next_pc); end
        total++; if (stk_lvl !== 3'd0 || in_isr !== 1'b0 || stk_err !== 1'b0 || irq_ack !== 4'b0) begin bad++; $display("FAIL async_rst_state: lvl=%0d isr=%b err=%b ack=%b want 0/0/0/0000", stk_lvl, in_isr, stk_err, irq_ack); end
        drive(0, 0, 4'b0, 0, 0, 0, 16'h0);
        #1 rst = 1'b0;
        cycle();
        total++; if (pc !== 16'h0001) begin bad++; $display("FAIL post_rst_inc: pc=%h want 0001", pc); end
        drive(0, 1, 4'b0, 0, 0, 0, 16'h0); cycle();
        total++; if (stk_err !== 1'b1 || pc !== 16'h0002) begin bad++; $display("FAIL stack_discarded: err=%b pc=%h want 1/0002", stk_err, pc); end
    endtask

    task automatic test_random();
        rst = 1'b1; model_reset();
        drive(0, 0, 4'b0, 0, 0, 0, 16'h0);
        #2 rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
                  ($urandom_range(0, 99) < 35) ? 4'($urandom) : 4'b0,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 20, 16'($urandom));
            cycle();
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
            total++; if (next_pc !== m_pc + 16'd1) begin bad++; $display("FAIL rnd_next[%0d]: got %h want %h", n, next_pc, m_pc + 16'd1); end
            total++; if (irq_ack !== m_ack) begin bad++; $display("FAIL rnd_ack[%0d]: got %b want %b", n, irq_ack, m_ack); end
            total++; if (stk_lvl !== 3'(m_stack.size())) begin bad++; $display("FAIL rnd_lvl[%0d]: got %0d want %0d", n, stk_lvl, m_stack.size()); end
            total++; if (stk_full !== (m_stack.size() == DEPTH)) begin bad++; $display("FAIL rnd_full[%0d]: got %b", n, stk_full); end
            total++; if (in_isr !== (m_stack.size() != 0)) begin bad++; $display("FAIL rnd_isr[%0d]: got %b", n, in_isr); end
            total++; if (stk_err !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", n, stk_err, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_jumps();
        test_irq_take();
        test_reti_priority();
        test_nesting();
        test_err_stall();
        test_rst_mid_isr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter AW, default 16: address width.
REQ-002 SHALL have parameter NIRQ, default 4: number of interrupt channels.
REQ-003 SHALL have parameter DEPTH, default 4: return-address stack depth (2..16).
REQ-004 SHALL have parameter VEC_BASE, default 2, and parameter VEC_STRIDE, default 2: vector of channel i = VEC_BASE + i*VEC_STRIDE.
REQ-005 SHALL have ports in order: clk in 1 (clock); rst in 1 (reset, asynchronous, active-high).
REQ-006 SHALL have port alu_in, input, AW bits: jump target or relative offset.
REQ-007 SHALL have port abs_jmp, input, 1 bit: absolute jump request.
REQ-008 SHALL have port rel_jmp, input, 1 bit: relative jump request.
REQ-009 SHALL have port stall, input, 1 bit: freeze the sequencer for this cycle.
REQ-010 SHALL have port irq, input, NIRQ bits: level interrupt requests.
REQ-011 SHALL have port irq_en, input, 1 bit: global interrupt enable.
REQ-012 SHALL have port reti, input, 1 bit: return from interrupt.
REQ-013 SHALL have ports pc and next_pc, outputs, AW bits: current and current+1 address.
REQ-014 SHALL have port irq_ack, output, NIRQ bits: one-hot, one-cycle pulse for the taken channel.
REQ-015 SHALL have ports in_isr (out, 1), stk_full (out, 1), stk_lvl (out, clog2(DEPTH+1)) and stk_err (out, 1; sticky).

Function
REQ-016 SHALL update only on posedge clk; all outputs SHALL be registered except stk_full.
REQ-017 SHALL resolve per-cycle priority as: stall > reti > irq take > rel_jmp > abs_jmp > increment.
REQ-018 On stall: pc, next_pc and stack SHALL hold; irq_ack SHALL stay 0; pending irq SHALL be taken no earlier than the first unstalled cycle.
REQ-019 Increment: pc <= pc+1, next_pc <= pc+2.
REQ-020 rel_jmp: pc <= pc+alu_in+1, next_pc <= pc+alu_in+2.
REQ-021 abs_jmp: pc <= alu_in, next_pc <= alu_in+1.
REQ-022 All address arithmetic SHALL be modulo 2^AW; wrap from all-ones to 0 is legal and silent.
REQ-023 next_pc SHALL equal pc+1 (mod 2^AW) in every cycle.
REQ-024 An irq is taken when irq_en=1, |irq=1 and stk_full=0; the lowest-index asserted channel wins.
REQ-025 On take: push return address (pc if rel_jmp or abs_jmp is asserted, else pc+1), pc <= vector, next_pc <= vector+1, set that channel's irq_ack for one cycle.
REQ-026 On reti with stk_lvl>0: pop; pc <= popped, next_pc <= popped+1.
REQ-027 reti with stk_lvl=0 SHALL set stk_err and SHALL otherwise behave as increment.
REQ-028 reti and an eligible irq in the same cycle: reti executes; the irq is re-evaluated next cycle.
REQ-029 Nesting SHALL be allowed up to DEPTH levels; at stk_lvl=DEPTH, stk_full=1 and irqs SHALL be held off without loss (level sensitive).
REQ-030 in_isr SHALL equal (stk_lvl != 0).

Reset
REQ-031 rst SHALL asynchronously force pc=0, next_pc=1, stk_lvl=0, irq_ack=0, stk_err=0, in_isr=0.
REQ-032 rst asserted mid-ISR SHALL discard all stacked addresses; stack contents need not be cleared.
REQ-033 The first posedge after rst deassertion SHALL apply normal REQ-017 rules.

Structure
REQ-034 A shared package pc_seq_pkg SHALL hold default parameter constants and a lowest-index priority-encoder function.
REQ-035 The LIFO SHALL be a sub-module ret_stack (params AW, DEPTH; push, pop, din, dout, lvl, full, empty).
REQ-036 The total RTL size SHALL be 120-400 lines.

Verification
REQ-037 The bench SHALL cover: reset, then 5 clocks idle -> pc=5, next_pc=6; with pc=0xFFFF and AW=16, the next increment -> pc=0, next_pc=1.
REQ-038 The bench SHALL cover: pc=0x10, rel_jmp with alu_in=0xFFFE -> pc=0x0F; abs_jmp with alu_in=0x1234 -> pc=0x1234, next_pc=0x1235.
REQ-039 The bench SHALL cover: pc=0x20, irq=4'b0110 with irq_en=1 -> irq_ack=4'b0010, pc=0x04, stk_lvl=1; then reti -> pc=0x21, stk_lvl=0.
REQ-040 The bench SHALL cover: DEPTH=4 with 4 nested takes -> stk_full=1 and a further irq is not acked; after reti the held irq is taken on the next cycle.
REQ-041 The bench SHALL cover: reti at stk_lvl=0 -> stk_err=1 and pc+1; stall held 3 cycles with irq=1 -> pc frozen and irq_ack=0 until stall drops.
REQ-042 The bench SHALL cover: rst pulse mid-ISR at stk_lvl=2 -> pc=0, stk_lvl=0, in_isr=0 immediately, without waiting for a clock edge.
